// File: rtl/sha1_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha1_padder
// Brief    : SHA-1 byte-stream padder; emits padded 512-bit blocks in the
//            core's message_in word order. Optional macro: SHA1_PAD_LEN_ERR_EN
// Revision : 1.0
// ============================================================================
module sha1_padder #(
    parameter int CNT_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   data_in,
    input  logic         data_valid,
    input  logic         data_last,
    input  logic         data_none,
    output logic         data_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready,
    output logic         len_err
);

    localparam logic [2:0] S_FILL      = 3'd0;
    localparam logic [2:0] S_PAD       = 3'd1;
    localparam logic [2:0] S_EMIT      = 3'd2;
    localparam logic [2:0] S_EXTRA     = 3'd3;
    localparam logic [2:0] S_EMIT_LAST = 3'd4;

    logic [2:0]           r_state;
    logic [6:0]           r_ptr;      // holds p_end from the last beat until the block sequence ends
    logic [CNT_WIDTH-1:0] r_count;
    logic [511:0]         r_buf;
    logic                 r_extra;

    logic [511:0]         w_buf_nxt;
    logic [63:0]          w_len;
    logic                 w_accept;
    logic                 w_write;

    // Byte k sits in word k/4, big-endian within the word.
    function automatic int f_lo(input int k);
        return 32 * (k / 4) + 24 - 8 * (k % 4);
    endfunction

    assign w_len       = 64'({r_count, 3'b000});
    assign data_ready  = (r_state == S_FILL);
    assign w_accept    = data_valid && data_ready;
    assign w_write     = w_accept && !data_none;
    assign block_valid = (r_state == S_EMIT) || (r_state == S_EMIT_LAST);
    assign block_last  = (r_state == S_EMIT_LAST);
    assign block_out   = r_buf;

    always_comb begin
        w_buf_nxt = r_buf;
        case (r_state)
            S_FILL: begin
                if (w_write) begin
                    w_buf_nxt[f_lo(int'(r_ptr[5:0])) +: 8] = data_in;
                end
            end
            S_PAD: begin
                for (int k = 0; k < 64; k++) begin
                    if (k == int'(r_ptr)) begin
                        w_buf_nxt[f_lo(k) +: 8] = 8'h80;
                    end else if (k > int'(r_ptr)) begin
                        w_buf_nxt[f_lo(k) +: 8] = 8'h00;
                    end
                end
                if (r_ptr <= 7'd55) begin
                    w_buf_nxt[479:448] = w_len[63:32];
                    w_buf_nxt[511:480] = w_len[31:0];
                end
            end
            S_EXTRA: begin
                w_buf_nxt = '0;
                if (r_ptr == 7'd64) begin
                    w_buf_nxt[31:24] = 8'h80;
                end
                w_buf_nxt[479:448] = w_len[63:32];
                w_buf_nxt[511:480] = w_len[31:0];
            end
            default: begin
                w_buf_nxt = r_buf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
            r_ptr   <= '0;
            r_count <= '0;
            r_buf   <= '0;
            r_extra <= 1'b0;
        end else begin
            r_buf <= w_buf_nxt;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (w_write) begin
                            r_count <= r_count + 1'b1;
                        end
                        if (data_last) begin
                            r_state <= S_PAD;
                            if (w_write) begin
                                r_ptr <= r_ptr + 7'd1;
                            end
                        end else if (w_write) begin
                            if (r_ptr == 7'd63) begin
                                r_state <= S_EMIT;
                                r_ptr   <= '0;
                                r_extra <= 1'b0;
                            end else begin
                                r_ptr <= r_ptr + 7'd1;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (r_ptr <= 7'd55) begin
                        r_state <= S_EMIT_LAST;
                    end else begin
                        r_state <= S_EMIT;
                        r_extra <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (block_ready) begin
                        if (r_extra) begin
                            r_state <= S_EXTRA;
                            r_extra <= 1'b0;
                        end else begin
                            r_state <= S_FILL;
                            r_ptr   <= '0;
                        end
                    end
                end
                S_EXTRA: begin
                    r_state <= S_EMIT_LAST;
                end
                S_EMIT_LAST: begin
                    if (block_ready) begin
                        r_state <= S_FILL;
                        r_ptr   <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

`ifdef SHA1_PAD_LEN_ERR_EN
    logic r_len_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len_err <= 1'b0;
        end else if (w_write && (&r_count)) begin
            r_len_err <= 1'b1;
        end
    end

    assign len_err = r_len_err;
`else
    assign len_err = 1'b0;
`endif

endmodule
`default_nettype wire
